adc_word_aligner: RTL

Recovers sample-word alignment from the raw ADC deserializer output and presents two aligned 12-bit samples per `lclk` cycle. It sits directly upstream of `waveform_acquisition` and replaces `data_gen` on its `adc_samp_0_0` / `adc_samp_1_0` inputs. A training state machine searches bit offsets 0..23 against a known ADC test pattern, then locks and holds the winning offset for normal acquisition.

---
 rtl/wdc_align_pkg.sv | 20 ++
 rtl/adc_bit_window.sv | 40 ++++
 rtl/adc_word_aligner.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/wdc_align_pkg.sv
// Shared types and constants for the ADC word aligner.
package wdc_align_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_CHECK  = 3'd2,
        ST_LOCKED = 3'd3,
        ST_FAIL   = 3'd4
    } align_state_t;

    localparam int L_RAW_WIDTH    = 24;
    localparam int L_OFFSET_WIDTH = 5;
    localparam logic [L_OFFSET_WIDTH-1:0] L_MAX_OFFSET = 5'd23;

    function automatic logic [L_OFFSET_WIDTH-1:0] clamp_offset(input logic [L_OFFSET_WIDTH-1:0] v);
        return (v > L_MAX_OFFSET) ? L_MAX_OFFSET : v;
    endfunction

endpackage

// File: rtl/adc_bit_window.sv
// Keeps the previous deserializer word and selects a registered 24-bit
// window from the concatenation {current, previous} at the given bit offset.
module adc_bit_window
    import wdc_align_pkg::*;
#(
    parameter int P_SAMP_WIDTH = L_RAW_WIDTH / 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [2*P_SAMP_WIDTH-1:0]   raw_i,
    input  logic [L_OFFSET_WIDTH-1:0]   offset_i,
    output logic [2*P_SAMP_WIDTH-1:0]   win_o
);

    localparam int L_W = 2 * P_SAMP_WIDTH;

    logic [L_W-1:0]   raw_q;
    logic [L_W-1:0]   win_q;
    logic [L_W-1:0]   win_d;
    logic [2*L_W-1:0] cat_shift;

    // Older word sits in the low half because bit 0 is the earliest bit.
    always_comb begin
        cat_shift = {raw_i, raw_q} >> offset_i;
        win_d     = cat_shift[L_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_q <= '0;
            win_q <= '0;
        end else begin
            raw_q <= raw_i;
            win_q <= win_d;
        end
    end

    assign win_o = win_q;

endmodule

// File: rtl/adc_word_aligner.sv
// Training FSM that searches bit offsets 0..23 for the ADC test pattern and
// locks the winning offset. Optional manual override: WDC_ALIGN_MANUAL_EN.
//
// state  | meaning
// IDLE   | waiting for train_req
// SETTLE | flushing the window pipeline after an offset change
// CHECK  | counting consecutive pattern matches at the current offset
// LOCKED | alignment found, offset frozen
// FAIL   | no offset matched
module adc_word_aligner
    import wdc_align_pkg::*;
#(
    parameter int P_SAMP_WIDTH = L_RAW_WIDTH / 2,
    parameter int P_SETTLE     = 4,
    parameter int P_MATCH_CNT  = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [2*P_SAMP_WIDTH-1:0]   raw_in,
    input  logic                        train_req,
    input  logic [P_SAMP_WIDTH-1:0]     pattern,
`ifdef WDC_ALIGN_MANUAL_EN
    input  logic                        manual_en,
    input  logic [L_OFFSET_WIDTH-1:0]   manual_offset,
`endif
    output logic [P_SAMP_WIDTH-1:0]     adc_samp_0,
    output logic [P_SAMP_WIDTH-1:0]     adc_samp_1,
    output logic [L_OFFSET_WIDTH-1:0]   offset,
    output logic                        busy,
    output logic                        locked,
    output logic                        train_fail
);

    localparam int L_SET_W   = (P_SETTLE > 1) ? $clog2(P_SETTLE) : 1;
    localparam int L_MATCH_W = $clog2(P_MATCH_CNT + 1);
    localparam logic [L_SET_W-1:0]   L_SETTLE_LAST = L_SET_W'(P_SETTLE - 1);
    localparam logic [L_MATCH_W-1:0] L_MATCH_TC    = L_MATCH_W'(P_MATCH_CNT);

    align_state_t                state_q;
    logic [L_OFFSET_WIDTH-1:0]   offset_q;
    logic                        busy_q;
    logic                        locked_q;
    logic                        fail_q;
    logic [L_SET_W-1:0]          settle_cnt_q;
    logic [L_MATCH_W-1:0]        match_cnt_q;

    logic [2*P_SAMP_WIDTH-1:0]   win;
    logic                        sample_match;

    adc_bit_window #(
        .P_SAMP_WIDTH (P_SAMP_WIDTH)
    ) u_window (
        .clk      (clk),
        .rst_n    (rst_n),
        .raw_i    (raw_in),
        .offset_i (offset_q),
        .win_o    (win)
    );

    assign adc_samp_0   = win[P_SAMP_WIDTH-1:0];
    assign adc_samp_1   = win[2*P_SAMP_WIDTH-1:P_SAMP_WIDTH];
    assign sample_match = (adc_samp_0 == pattern) && (adc_samp_1 == pattern);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            offset_q     <= '0;
            busy_q       <= 1'b0;
            locked_q     <= 1'b0;
            fail_q       <= 1'b0;
            settle_cnt_q <= '0;
            match_cnt_q  <= '0;
        end else begin
`ifdef WDC_ALIGN_MANUAL_EN
            if (manual_en) begin
                state_q      <= ST_IDLE;
                offset_q     <= clamp_offset(manual_offset);
                busy_q       <= 1'b0;
                locked_q     <= 1'b0;
                fail_q       <= 1'b0;
                settle_cnt_q <= '0;
                match_cnt_q  <= '0;
            end else
`endif
            if (train_req) begin
                state_q      <= ST_SETTLE;
                offset_q     <= '0;
                busy_q       <= 1'b1;
                locked_q     <= 1'b0;
                fail_q       <= 1'b0;
                settle_cnt_q <= '0;
                match_cnt_q  <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        busy_q <= 1'b0;
                    end
                    ST_SETTLE: begin
                        if (settle_cnt_q == L_SETTLE_LAST) begin
                            settle_cnt_q <= '0;
                            state_q      <= ST_CHECK;
                        end else begin
                            settle_cnt_q <= settle_cnt_q + 1'b1;
                        end
                    end
                    ST_CHECK: begin
                        // Terminal count is seen one cycle after the last match.
                        if (match_cnt_q == L_MATCH_TC) begin
                            state_q     <= ST_LOCKED;
                            busy_q      <= 1'b0;
                            locked_q    <= 1'b1;
                            match_cnt_q <= '0;
                        end else if (sample_match) begin
                            match_cnt_q <= match_cnt_q + 1'b1;
                        end else if (offset_q == L_MAX_OFFSET) begin
                            state_q     <= ST_FAIL;
                            offset_q    <= '0;
                            busy_q      <= 1'b0;
                            fail_q      <= 1'b1;
                            match_cnt_q <= '0;
                        end else begin
                            state_q     <= ST_SETTLE;
                            offset_q    <= offset_q + 5'd1;
                            match_cnt_q <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        locked_q <= 1'b1;
                    end
                    ST_FAIL: begin
                        fail_q <= 1'b1;
                    end
                    default: begin
                        state_q  <= ST_IDLE;
                        busy_q   <= 1'b0;
                        locked_q <= 1'b0;
                        fail_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign offset     = offset_q;
    assign busy       = busy_q;
    assign locked     = locked_q;
    assign train_fail = fail_q;

endmodule
